// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between CPU fetch, CPU data and the debug port.
module ram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              override,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_load,
  output logic              i_wait,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_store,
  output logic [DATA_W-1:0] d_load,
  output logic              d_wait,
  input  logic              g_ren,
  input  logic              g_wen,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] g_store,
  output logic [DATA_W-1:0] g_load,
  output logic              g_wait,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;
  localparam logic [1:0] O_NONE = 2'd0;
  localparam logic [1:0] O_I    = 2'd1;
  localparam logic [1:0] O_D    = 2'd2;
  localparam logic [1:0] O_G    = 2'd3;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic              state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              ren_q, ren_d, wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_load_q, d_load_q, g_load_q;
  logic              d_req, g_req, idle, done, i_hit, d_hit, g_hit;
  logic              grant_f, grant_d, grant_g, grant;

  always_comb begin
    d_req    = d_ren | d_wen;
    g_req    = g_ren | g_wen;
    idle     = state_q == S_IDLE;
    done     = state_q == S_BUSY & ram_ready;
    i_hit    = done & owner_q == O_I;
    d_hit    = done & owner_q == O_D;
    g_hit    = done & owner_q == O_G;
    // fetch only beats data once data has been granted STARVE_MAX times in a row
    grant_g  = idle & override & g_req;
    grant_f  = idle & ~override & i_ren & (~d_req | starve_q == SMAX);
    grant_d  = idle & ~override & d_req & ~grant_f;
    grant    = grant_f | grant_d | grant_g;
    starve_d = (~i_ren | grant_f) ? '0 : (grant_d & starve_q != SMAX) ? starve_q + 1'b1 : starve_q;
    state_d  = grant ? S_BUSY : done ? S_IDLE : state_q;
    owner_d  = grant_g ? O_G : grant_d ? O_D : grant_f ? O_I : done ? O_NONE : owner_q;
    ren_d    = grant ? (grant_f | (grant_d & ~d_wen) | (grant_g & ~g_wen)) : done ? 1'b0 : ren_q;
    wen_d    = grant ? ((grant_d & d_wen) | (grant_g & g_wen)) : done ? 1'b0 : wen_q;
    addr_d   = grant_g ? g_addr : grant_d ? d_addr : grant_f ? i_addr : addr_q;
    wdata_d  = grant_g ? g_store : grant_d ? d_store : grant_f ? '0 : wdata_q;
    i_load   = (i_hit & i_ren) ? ram_rdata : i_load_q;
    d_load   = (d_hit & d_ren) ? ram_rdata : d_load_q;
    g_load   = (g_hit & g_ren) ? ram_rdata : g_load_q;
    i_wait   = i_ren & ~i_hit;
    d_wait   = d_req & ~d_hit;
    g_wait   = g_req & ~g_hit;
    ram_ren  = ren_q;
    ram_wen  = wen_q;
    ram_addr = addr_q;
    ram_wdata = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= O_NONE;
      starve_q <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      i_load_q <= '0;
      d_load_q <= '0;
      g_load_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      i_load_q <= i_load;
      d_load_q <= d_load;
      g_load_q <= g_load;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios checked against a transaction-level arbiter model and a RAM responder.
module tb_ram_port_arbiter;
  logic clk = 0, rst = 1, override = 0;
  logic i_ren = 0, d_ren = 0, d_wen = 0, g_ren = 0, g_wen = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_store = 0, g_addr = 0, g_store = 0;
  logic [31:0] i_load, d_load, g_load, ram_addr, ram_wdata;
  logic [31:0] ram_rdata = 32'hBAD0BAD0;
  logic i_wait, d_wait, g_wait, ram_ren, ram_wen, ram_ready = 0;

  ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .override(override),
    .i_ren(i_ren), .i_addr(i_addr), .i_load(i_load), .i_wait(i_wait),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store), .d_load(d_load), .d_wait(d_wait),
    .g_ren(g_ren), .g_wen(g_wen), .g_addr(g_addr), .g_store(g_store), .g_load(g_load), .g_wait(g_wait),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, lat = 1, k;
  bit chk_en = 0;
  logic [31:0] mem [logic [31:0]];
  int glog[$];
  logic [31:0] gaddr[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A0000);
  endfunction

  // RAM responder: ready arrives lat cycles after the strobe first appears
  initial begin
    int age = 0;
    bit prev = 0, st;
    forever begin
      @(posedge clk); #1;
      st = (ram_ren === 1'b1) || (ram_wen === 1'b1);
      age = prev ? age + 1 : 0;
      prev = st;
      ram_ready = st && age == lat;
      ram_rdata = (ram_ready && ram_ren) ? mem_rd(ram_addr) : 32'hBAD0BAD0;
      if (ram_ready && ram_wen) mem[ram_addr] = ram_wdata;
    end
  end

  // transaction-level model: one access in flight, owner chosen by the grant rules
  initial begin
    bit m_busy = 0, m_wr = 0, done;
    int m_own = 0, m_starve = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        done = m_busy && ram_ready;
        chk("ram_ren", {31'd0, ram_ren}, {31'd0, m_busy & ~m_wr});
        chk("ram_wen", {31'd0, ram_wen}, {31'd0, m_busy & m_wr});
        if (m_busy) chk("ram_addr", ram_addr, m_addr);
        if (m_busy && m_wr) chk("ram_wdata", ram_wdata, m_wdata);
        chk("i_wait", {31'd0, i_wait}, {31'd0, i_ren & ~(done && m_own == 1)});
        chk("d_wait", {31'd0, d_wait}, {31'd0, (d_ren | d_wen) & ~(done && m_own == 2)});
        chk("g_wait", {31'd0, g_wait}, {31'd0, (g_ren | g_wen) & ~(done && m_own == 3)});
        if (i_ren && !i_wait) chk("i_load", i_load, ram_rdata);
        if (d_ren && !d_wen && !d_wait) chk("d_load", d_load, ram_rdata);
        if (g_ren && !g_wen && !g_wait) chk("g_load", g_load, ram_rdata);
        if (rst) begin
          m_busy = 0; m_starve = 0;
        end else begin
          if (m_busy) begin
            if (ram_ready) m_busy = 0;
          end else if (override) begin
            if (g_ren || g_wen) begin
              m_busy = 1; m_own = 3; m_wr = g_wen; m_addr = g_addr; m_wdata = g_store;
            end
          end else if ((d_ren || d_wen) && !(m_starve == 4 && i_ren)) begin
            m_busy = 1; m_own = 2; m_wr = d_wen; m_addr = d_addr; m_wdata = d_store;
            m_starve = i_ren ? (m_starve < 4 ? m_starve + 1 : 4) : 0;
          end else if (i_ren) begin
            m_busy = 1; m_own = 1; m_wr = 0; m_addr = i_addr; m_starve = 0;
          end
          if (m_busy && !done && ram_ren !== 1'b1 && ram_wen !== 1'b1) begin
            glog.push_back(m_own);
            gaddr.push_back(m_addr);
          end
          if (!i_ren) m_starve = 0;
        end
      end
    end
  end

  function automatic logic wait_of(input int p);
    return p == 0 ? i_wait : p == 1 ? d_wait : g_wait;
  endfunction

  task automatic req_wait(input int p, output int cyc);
    cyc = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (wait_of(p) === 1'b0) begin
        cyc = n;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    automatic logic [31:0] dump_a[3] = '{32'h0, 32'h4, 32'h8};
    automatic logic [31:0] dump_v[3] = '{32'h5A5A0000, 32'h5A5A0004, 32'h5A5A0008};
    i_ren = 1;
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_i_wait", {31'd0, i_wait}, 32'd1);
    chk("rst_ram_ren", {31'd0, ram_ren}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_i_load", i_load, 32'd0);
    chk("rst_d_load", d_load, 32'd0);
    chk("rst_g_load", g_load, 32'd0);
    @(posedge clk); #1;
    rst = 0; i_ren = 0;
    idle(2);
    // single fetch
    mem[32'h10] = 32'hDEADBEEF; lat = 1;
    i_addr = 32'h10; i_ren = 1;
    req_wait(0, k);
    chk("fetch_lat", k, 2);
    chk("fetch_load", i_load, 32'hDEADBEEF);
    @(posedge clk); #1; i_ren = 0;
    idle(2);
    // contention: data write goes first, then the fetch
    glog.delete(); gaddr.delete();
    i_ren = 1; d_wen = 1; d_addr = 32'h80; d_store = 32'h55;
    req_wait(1, k);
    chk("cont_d_lat", k, 2);
    @(posedge clk); #1; d_wen = 0;
    req_wait(0, k);
    chk("cont_i_lat", k, 2);
    chk("cont_i_load", i_load, 32'hDEADBEEF);
    chk("cont_mem80", mem_rd(32'h80), 32'h55);
    chk("cont_g0", glog[0], 2);
    chk("cont_g1", glog[1], 1);
    chk("cont_a0", gaddr[0], 32'h80);
    chk("cont_a1", gaddr[1], 32'h10);
    @(posedge clk); #1; i_ren = 0;
    idle(2);
    // starvation: four data grants, then fetch is forced
    glog.delete(); gaddr.delete(); lat = 0;
    i_addr = 32'h20; d_addr = 32'h40; i_ren = 1; d_ren = 1;
    idle(12);
    i_ren = 0; d_ren = 0;
    idle(3);
    chk("starve_n", glog.size(), 6);
    for (int n = 0; n < 6; n++) chk($sformatf("starve_g%0d", n), glog[n], n == 4 ? 1 : 2);
    // override raised while a data read is in flight
    glog.delete(); gaddr.delete(); lat = 3;
    d_ren = 1; d_addr = 32'h80; g_ren = 1; g_addr = 32'h10; i_ren = 1;
    @(posedge clk); #1; override = 1;
    req_wait(1, k);
    chk("ovr_d_lat", k, 3);
    chk("ovr_d_load", d_load, 32'h55);
    @(posedge clk); #1;
    req_wait(2, k);
    chk("ovr_g_lat", k, 4);
    chk("ovr_g_load", g_load, 32'hDEADBEEF);
    chk("ovr_i_wait", {31'd0, i_wait}, 32'd1);
    chk("ovr_d_wait", {31'd0, d_wait}, 32'd1);
    chk("ovr_g0", glog[0], 2);
    chk("ovr_g1", glog[1], 3);
    // debug dump sweep
    @(posedge clk); #1;
    lat = 0; glog.delete(); gaddr.delete();
    for (int n = 0; n < 3; n++) begin
      g_addr = dump_a[n];
      req_wait(2, k);
      chk($sformatf("dump_lat%0d", n), k, 1);
      chk($sformatf("dump_load%0d", n), g_load, dump_v[n]);
      @(posedge clk); #1;
    end
    g_ren = 0; override = 0; i_ren = 0; d_ren = 0;
    idle(3);
    chk("dump_n", glog.size(), 3);
    for (int n = 0; n < 3; n++) chk($sformatf("dump_a%0d", n), gaddr[n], dump_a[n]);
    // reset pulse during an access
    lat = 3; d_addr = 32'h40; d_ren = 1;
    idle(2);
    rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("rb_ram_ren", {31'd0, ram_ren}, 32'd0);
    chk("rb_ram_wen", {31'd0, ram_wen}, 32'd0);
    chk("rb_d_wait", {31'd0, d_wait}, 32'd1);
    @(posedge clk); #1;
    req_wait(1, k);
    chk("rb_lat", k, 3);
    chk("rb_load", d_load, 32'h5A5A0040);
    @(posedge clk); #1; d_ren = 0;
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
